// File: rtl/burst_port_scheduler_4_pkg.sv
// Shared types and helpers for the four-requester burst read-port scheduler.
package burst_port_scheduler_4_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Low bit position of slice idx inside a flattened bus of width-sized fields.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/burst_port_scheduler_4_rr_select.sv
// Combinational round-robin picker: first set req bit after the last winner.
module rr_select_4
    import burst_port_scheduler_4_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [3:0] winner,
    output logic [1:0] win_idx
);

    logic [1:0] cand [NUM_REQ];
    logic       found;

    // cand[0] is the highest-priority position (last+1), cand[3] wraps back to last.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        assign cand[gi] = last + 2'(gi + 1);
    end

    always_comb begin
        winner  = '0;
        win_idx = last;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[cand[i]]) begin
                found           = 1'b1;
                win_idx         = cand[i];
                winner[cand[i]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/burst_port_scheduler_4.sv
// Round-robin owner of one buffer read port; replays each granted burst as an address/enable stream.
module burst_port_scheduler_4
    import burst_port_scheduler_4_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [3:0]                  req,
    input  logic [NUM_REQ*ADDR_W-1:0]   base_addr,
    input  logic [NUM_REQ*LEN_W-1:0]    len,
    output logic [3:0]                  grant,
    output logic                        mem_en,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic                        mem_last,
    output logic [3:0]                  done,
    output logic                        busy
);

    logic [ADDR_W-1:0] base_arr [NUM_REQ];
    logic [LEN_W-1:0]  len_arr  [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign base_arr[gi] = base_addr[slice_lo(gi, ADDR_W) +: ADDR_W];
        assign len_arr[gi]  = len[slice_lo(gi, LEN_W) +: LEN_W];
    end

    logic [3:0] winner;
    logic [1:0] win_idx;

    state_t            state_reg, state_next;
    logic [1:0]        last_reg, last_next;
    logic [LEN_W-1:0]  beat_reg, beat_next;
    logic [LEN_W-1:0]  len_reg, len_next;
    logic [3:0]        owner_reg, owner_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [3:0]        grant_reg, grant_next;
    logic              en_reg, en_next;
    logic              final_reg, final_next;
    logic [3:0]        done_reg, done_next;
    logic              busy_reg, busy_next;
    logic [LEN_W-1:0]  beat_inc;

    rr_select_4 u_rr_select (
        .req     (req),
        .last    (last_reg),
        .winner  (winner),
        .win_idx (win_idx)
    );

    assign beat_inc = beat_reg + LEN_W'(1);

    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        beat_next  = beat_reg;
        len_next   = len_reg;
        owner_next = owner_reg;
        addr_next  = addr_reg;
        grant_next = grant_reg;
        en_next    = en_reg;
        final_next = final_reg;
        done_next  = '0;

        case (state_reg)
            ST_IDLE: begin
                grant_next = '0;
                en_next    = 1'b0;
                final_next = 1'b0;
                if (req != '0) begin
                    last_next  = win_idx;
                    owner_next = winner;
                    len_next   = len_arr[win_idx];
                    beat_next  = '0;
                    if (len_arr[win_idx] != '0) begin
                        state_next = ST_BURST;
                        addr_next  = base_arr[win_idx];
                        grant_next = winner;
                        en_next    = 1'b1;
                        final_next = (len_arr[win_idx] == LEN_W'(1));
                    end else begin
                        // Empty burst: skip the port entirely and just acknowledge.
                        state_next = ST_GAP;
                        done_next  = winner;
                    end
                end
            end
            ST_BURST: begin
                if (beat_reg == len_reg - LEN_W'(1)) begin
                    state_next = ST_GAP;
                    grant_next = '0;
                    en_next    = 1'b0;
                    final_next = 1'b0;
                    done_next  = owner_reg;
                end else begin
                    beat_next  = beat_inc;
                    addr_next  = addr_reg + ADDR_W'(1);
                    final_next = (beat_inc == len_reg - LEN_W'(1));
                end
            end
            ST_GAP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
                en_next    = 1'b0;
                final_next = 1'b0;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            last_reg  <= 2'd3;
            beat_reg  <= '0;
            len_reg   <= '0;
            owner_reg <= '0;
            addr_reg  <= '0;
            grant_reg <= '0;
            en_reg    <= 1'b0;
            final_reg <= 1'b0;
            done_reg  <= '0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            beat_reg  <= beat_next;
            len_reg   <= len_next;
            owner_reg <= owner_next;
            addr_reg  <= addr_next;
            grant_reg <= grant_next;
            en_reg    <= en_next;
            final_reg <= final_next;
            done_reg  <= done_next;
            busy_reg  <= busy_next;
        end
    end

    assign grant    = grant_reg;
    assign mem_en   = en_reg;
    assign mem_addr = addr_reg;
    assign mem_last = final_reg;
    assign done     = done_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_burst_port_scheduler_4.sv
// Directed bench for burst_port_scheduler_4: hand-computed per-cycle outputs.
module tb_burst_port_scheduler_4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [9:0]  b [4];
    logic [5:0]  l [4];
    logic [39:0] base_addr;
    logic [23:0] len;
    logic [3:0]  grant;
    logic        mem_en;
    logic [9:0]  mem_addr;
    logic        mem_last;
    logic [3:0]  done;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    assign base_addr = {b[3], b[2], b[1], b[0]};
    assign len       = {l[3], l[2], l[1], l[0]};

    always #5 clk = ~clk;

    burst_port_scheduler_4 #(.ADDR_W(10), .LEN_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .base_addr (base_addr),
        .len       (len),
        .grant     (grant),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_last  (mem_last),
        .done      (done),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Address is only meaningful while mem_en is high, so it is checked only then.
    task automatic outs(input string tag, input logic [3:0] eg, input logic een,
                        input logic [9:0] ea, input logic el, input logic [3:0] ed,
                        input logic eb);
        chk({tag, "_grant"}, grant, eg);
        chk({tag, "_en"}, mem_en, een);
        if (een) chk({tag, "_addr"}, mem_addr, ea);
        chk({tag, "_last"}, mem_last, el);
        chk({tag, "_done"}, done, ed);
        chk({tag, "_busy"}, busy, eb);
        $display("step %-10s grant=%b en=%b addr=%0d last=%b done=%b busy=%b",
                 tag, grant, mem_en, mem_addr, mem_last, done, busy);
    endtask

    logic [3:0] order [5];

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            b[i] = 10'd0;
            l[i] = 6'd0;
        end
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;

        tick(); tick();
        outs("reset", 4'b0000, 0, 10'd0, 0, 4'b0000, 0);
        chk("reset_addr", mem_addr, 10'd0);

        // Single burst from requester 0
        rst = 1'b0;
        b[0] = 10'd10; l[0] = 6'd3; req = 4'b0001;
        tick(); req = 4'b0000;
        outs("b0_beat0", 4'b0001, 1, 10'd10, 0, 4'b0000, 1);
        tick(); outs("b0_beat1", 4'b0001, 1, 10'd11, 0, 4'b0000, 1);
        tick(); outs("b0_beat2", 4'b0001, 1, 10'd12, 1, 4'b0000, 1);
        tick(); outs("b0_gap", 4'b0000, 0, 10'd0, 0, 4'b0001, 1);
        tick(); outs("b0_idle", 4'b0000, 0, 10'd0, 0, 4'b0000, 0);

        // Round robin with all requesters pending and len=1 from a fresh pointer
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b[i] = 10'(100 + i * 10);
            l[i] = 6'd1;
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int w;
            w = (k == 4) ? 0 : k;
            tick(); outs($sformatf("rr%0d_beat", k), order[k], 1, 10'(100 + w * 10), 1, 4'b0000, 1);
            tick(); outs($sformatf("rr%0d_gap", k), 4'b0000, 0, 10'd0, 0, order[k], 1);
            tick(); outs($sformatf("rr%0d_idle", k), 4'b0000, 0, 10'd0, 0, 4'b0000, 0);
        end
        req = 4'b0000;

        // Address wrap at the top of the buffer
        b[2] = 10'd1022; l[2] = 6'd4; req = 4'b0100;
        tick(); req = 4'b0000;
        outs("wrap_b0", 4'b0100, 1, 10'd1022, 0, 4'b0000, 1);
        tick(); outs("wrap_b1", 4'b0100, 1, 10'd1023, 0, 4'b0000, 1);
        tick(); outs("wrap_b2", 4'b0100, 1, 10'd0, 0, 4'b0000, 1);
        tick(); outs("wrap_b3", 4'b0100, 1, 10'd1, 1, 4'b0000, 1);
        tick(); outs("wrap_gap", 4'b0000, 0, 10'd0, 0, 4'b0100, 1);
        tick(); outs("wrap_idle", 4'b0000, 0, 10'd0, 0, 4'b0000, 0);

        // Zero-length burst
        l[2] = 6'd0; req = 4'b0100;
        tick(); req = 4'b0000;
        outs("zero_gap", 4'b0000, 0, 10'd0, 0, 4'b0100, 1);
        tick(); outs("zero_idle", 4'b0000, 0, 10'd0, 0, 4'b0000, 0);

        // req1 drops and req3 rises mid-burst
        b[1] = 10'd200; l[1] = 6'd3; b[3] = 10'd300; l[3] = 6'd2;
        req = 4'b0010;
        tick(); req = 4'b1000;
        outs("sw_r1b0", 4'b0010, 1, 10'd200, 0, 4'b0000, 1);
        tick(); outs("sw_r1b1", 4'b0010, 1, 10'd201, 0, 4'b0000, 1);
        tick(); outs("sw_r1b2", 4'b0010, 1, 10'd202, 1, 4'b0000, 1);
        tick(); outs("sw_r1gap", 4'b0000, 0, 10'd0, 0, 4'b0010, 1);
        tick(); outs("sw_idle", 4'b0000, 0, 10'd0, 0, 4'b0000, 0);
        tick(); req = 4'b0000;
        outs("sw_r3b0", 4'b1000, 1, 10'd300, 0, 4'b0000, 1);
        tick(); outs("sw_r3b1", 4'b1000, 1, 10'd301, 1, 4'b0000, 1);
        tick(); outs("sw_r3gap", 4'b0000, 0, 10'd0, 0, 4'b1000, 1);
        tick(); outs("sw_idle2", 4'b0000, 0, 10'd0, 0, 4'b0000, 0);

        // Reset on the second beat of a len=5 burst
        b[0] = 10'd50; l[0] = 6'd5; req = 4'b0001;
        tick(); req = 4'b0000;
        outs("rst_b0", 4'b0001, 1, 10'd50, 0, 4'b0000, 1);
        tick(); outs("rst_b1", 4'b0001, 1, 10'd51, 0, 4'b0000, 1);
        rst = 1'b1;
        tick(); rst = 1'b0;
        outs("rst_after", 4'b0000, 0, 10'd0, 0, 4'b0000, 0);
        chk("rst_after_addr", mem_addr, 10'd0);
        b[1] = 10'd60; l[1] = 6'd1; l[0] = 6'd2; req = 4'b0011;
        tick(); req = 4'b0000;
        outs("post_b0", 4'b0001, 1, 10'd50, 0, 4'b0000, 1);
        tick(); outs("post_b1", 4'b0001, 1, 10'd51, 1, 4'b0000, 1);
        tick(); outs("post_gap", 4'b0000, 0, 10'd0, 0, 4'b0001, 1);
        tick(); outs("post_idle", 4'b0000, 0, 10'd0, 0, 4'b0000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
